// File: rtl/stopwatch_pkg.sv
// Shared stopwatch display definitions: active-low segment patterns {g,f,e,d,c,b,a}
// and the scanner state encoding.
package stopwatch_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {IDLE, SCAN} scan_state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show a dash.
module bcd_to_seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed seven-segment scanner with per-frame shadow capture.
// Optional leading-zero blanking: define BCD_LEADING_ZERO_BLANK_EN.
module bcd_display_scanner
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    Clk,
    input  logic                    nReset,
    input  logic                    Enable,
    input  logic [4*NUM_DIGITS-1:0] Digits_in,
    input  logic [NUM_DIGITS-1:0]   Dp_in,
    output logic [6:0]              Seg_out,
    output logic                    Dp_out,
    output logic [NUM_DIGITS-1:0]   An_out,
    output logic                    Frame_tick
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state;
    logic [PRE_W-1:0]        pre;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_lz;
    logic [NUM_DIGITS-1:0]   lz_next;
    logic                    frame_start_q;
    logic                    wrap;
    logic                    load;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_lz;
    logic [6:0]              dec_seg;

    always_comb begin
        wrap = (state == SCAN) && Enable && (pre == PRE_LAST) && (idx == IDX_LAST);
        load = ((state == IDLE) && Enable) || wrap;
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every more significant digit are zero; digit 0 never is.
    logic all_zero_above;
    always_comb begin
        lz_next        = '0;
        all_zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero_above = all_zero_above && (Digits_in[4*k +: 4] == 4'd0);
            lz_next[k]     = all_zero_above;
        end
    end
`else
    always_comb begin
        lz_next = '0;
    end
`endif

    always_comb begin
        cur_code = '0;
        cur_dp   = 1'b0;
        cur_lz   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_code = sh_digits[4*k +: 4];
                cur_dp   = sh_dp[k];
                cur_lz   = sh_lz[k];
            end
        end
    end

    bcd_to_seg u_dec (
        .code (cur_code),
        .seg  (dec_seg)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state         <= IDLE;
            pre           <= '0;
            idx           <= '0;
            sh_digits     <= '0;
            sh_dp         <= '0;
            sh_lz         <= '0;
            frame_start_q <= 1'b0;
            Seg_out       <= SEG_BLANK;
            Dp_out        <= 1'b1;
            An_out        <= '1;
            Frame_tick    <= 1'b0;
        end else begin
            frame_start_q <= wrap;
            if (load) begin
                sh_digits <= Digits_in;
                sh_dp     <= Dp_in;
                sh_lz     <= lz_next;
            end

            case (state)
                IDLE: begin
                    pre <= '0;
                    idx <= '0;
                    if (Enable) state <= SCAN;
                end
                SCAN: begin
                    if (!Enable) begin
                        state <= IDLE;
                        pre   <= '0;
                        idx   <= '0;
                    end else if (pre == PRE_LAST) begin
                        pre <= '0;
                        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Outputs follow the previous cycle's state/index; the tick lines up with digit 0.
            if (state == SCAN) begin
                Seg_out    <= cur_lz ? SEG_BLANK : dec_seg;
                Dp_out     <= ~cur_dp;
                An_out     <= ~(NUM_DIGITS'(1) << idx);
                Frame_tick <= frame_start_q;
            end else begin
                Seg_out    <= SEG_BLANK;
                Dp_out     <= 1'b1;
                An_out     <= '1;
                Frame_tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner (4 digits, 4-cycle dwell) with a frame-level model.
module tb_bcd_display_scanner;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int FRAME = ND * SD;

    logic        Clk = 1'b0;
    logic        nReset = 1'b1;
    logic        Enable = 1'b0;
    logic [15:0] Digits_in = '0;
    logic [3:0]  Dp_in = '0;
    logic [6:0]  Seg_out;
    logic        Dp_out;
    logic [3:0]  An_out;
    logic        Frame_tick;

    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    logic [12:0] exp_q[$];
    logic [15:0] plan_d[$];
    logic [3:0]  plan_p[$];
    logic [12:0] mon_e;
    logic [12:0] mon_got;

    bcd_display_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .Enable     (Enable),
        .Digits_in  (Digits_in),
        .Dp_in      (Dp_in),
        .Seg_out    (Seg_out),
        .Dp_out     (Dp_out),
        .An_out     (An_out),
        .Frame_tick (Frame_tick)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (v > 4'd9) return 7'b0111111;
        return tbl[v];
    endfunction

    // Expected {tick, anode, dp, seg} while digit j of a frame holding d/p is shown.
    function automatic logic [12:0] expect_entry(input logic [15:0] d, input logic [3:0] p,
                                                 input int j, input bit tick);
        logic [6:0] s;
        logic [3:0] an;
        s  = seg_ref(d[4*j +: 4]);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        if (j > 0 && (d >> (4*j)) == 16'd0) s = 7'h7F;
`endif
        an = ~(4'b0001 << j);
        return {tick, an, ~p[j], s};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Enable for m displayed cycles starting at the current negedge; ends with Enable low.
    task automatic run_session(input int m);
        int k;
        int junk_pos;
        logic [15:0] d;
        logic [3:0]  p;
        k = 0;
        Enable = 1'b1;
        while (k < m) begin
            if (plan_d.size() > 0) begin
                d = plan_d.pop_front();
                p = plan_p.pop_front();
            end else begin
                d = 16'($urandom) >> (4 * $urandom_range(0, 3));
                p = 4'($urandom);
            end
            Digits_in = d;
            Dp_in     = p;
            junk_pos  = $urandom_range(1, 14);
            for (int c = 0; c < FRAME && k < m; c++) begin
                exp_q.push_back(expect_entry(d, p, c / SD, (k > 0) && (c == 0)));
                @(negedge Clk);
                k++;
                if (c == junk_pos) begin
                    Digits_in = (plan_d.size() > 0) ? plan_d[0] : 16'($urandom);
                    Dp_in     = 4'($urandom);
                end
            end
        end
        Enable = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (mon_en && nReset) begin
            checks++;
            mon_got = {Frame_tick, An_out, Dp_out, Seg_out};
            if (An_out != 4'hF || Frame_tick) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got %b expected blank", mon_got);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_got !== mon_e) begin
                        failures++;
                        $display("FAIL scan_output: got tick=%b an=%b dp=%b seg=%b expected tick=%b an=%b dp=%b seg=%b",
                                 mon_got[12], mon_got[11:8], mon_got[7], mon_got[6:0],
                                 mon_e[12], mon_e[11:8], mon_e[7], mon_e[6:0]);
                    end
                end
            end else if ({Dp_out, Seg_out} !== 8'hFF) begin
                failures++;
                $display("FAIL blank_segments: got dp=%b seg=%b expected dp=1 seg=1111111", Dp_out, Seg_out);
            end
        end
    end

    initial begin
        #1 nReset = 1'b0;
        #10;
        check("reset_seg", 32'(Seg_out), 32'h7F);
        check("reset_dp", 32'(Dp_out), 32'h1);
        check("reset_an", 32'(An_out), 32'hF);
        check("reset_tick", 32'(Frame_tick), 32'h0);
        @(negedge Clk);
        nReset = 1'b1;
        repeat (2) @(negedge Clk);
        check("idle_an", 32'(An_out), 32'hF);

        // Asynchronous reset in the middle of digit 1.
        Digits_in = 16'h1234;
        Dp_in     = 4'b0000;
        Enable    = 1'b1;
        repeat (7) @(negedge Clk);
        check("midscan_an", 32'(An_out), 32'hD);
        check("midscan_seg", 32'(Seg_out), 32'(7'b0110000));
        #2 nReset = 1'b0;
        #1;
        check("async_reset_seg", 32'(Seg_out), 32'h7F);
        check("async_reset_dp", 32'(Dp_out), 32'h1);
        check("async_reset_an", 32'(An_out), 32'hF);
        check("async_reset_tick", 32'(Frame_tick), 32'h0);
        Enable = 1'b0;
        @(negedge Clk);
        nReset = 1'b1;
        repeat (3) @(negedge Clk);
        check("post_reset_an", 32'(An_out), 32'hF);
        check("post_reset_seg", 32'(Seg_out), 32'h7F);

        mon_en = 1'b1;

        // Basic scan of 1234 over three frames.
        repeat (3) begin plan_d.push_back(16'h1234); plan_p.push_back(4'b0000); end
        run_session(3 * FRAME);
        repeat (3) @(negedge Clk);

        // Tear-free update: 9999 arrives mid-frame, shows from the next frame.
        plan_d.push_back(16'h1234); plan_p.push_back(4'b0000);
        plan_d.push_back(16'h9999); plan_p.push_back(4'b0000);
        run_session(2 * FRAME);
        repeat (2) @(negedge Clk);

        // Invalid code with a decimal point, then leading zeros.
        plan_d.push_back(16'h00A0); plan_p.push_back(4'b0010);
        plan_d.push_back(16'h0050); plan_p.push_back(4'b0000);
        run_session(2 * FRAME);
        repeat (2) @(negedge Clk);

        // Single-cycle Enable drop during digit 2 of the third frame.
        run_session(2 * FRAME + 2 * SD + 2);
        @(negedge Clk);
        run_session(2 * FRAME);
        repeat (2) @(negedge Clk);

        // Random sessions with random lengths and gaps.
        for (int s = 0; s < 10; s++) begin
            run_session($urandom_range(1, 3 * FRAME + 5));
            repeat ($urandom_range(1, 3)) @(negedge Clk);
        end

        repeat (4) @(negedge Clk);
        mon_en = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Time-multiplexed seven-segment driver for the stopwatch display path. It takes `NUM_DIGITS` packed BCD digits from the counter chain and scans them onto a shared common-anode segment bus. Each digit is driven for a fixed number of clock cycles. Digit values are captured once per frame, so the display never shows a mix of old and new digits.

## Interface
Parameters:
- `NUM_DIGITS`, 4, number of BCD digits scanned; legal range 2–8.
- `SCAN_DIV`, 50000, clock cycles each digit is driven; minimum 2.

Ports:
- `Clk`  in  1  system clock; all logic on the rising edge.
- `nReset`  in  1  reset: asynchronous, active-low.
- `Enable`  in  1  scan enable; low blanks the display and holds the scanner idle.
- `Digits_in`  in  4*NUM_DIGITS  packed BCD; `[3:0]` is digit 0, the least significant.
- `Dp_in`  in  NUM_DIGITS  decimal-point request per digit; active-high.
- `Seg_out`  out  7  segments `{g,f,e,d,c,b,a}`; active-low.
- `Dp_out`  out  1  decimal-point segment; active-low.
- `An_out`  out  NUM_DIGITS  digit anode select; active-low, one-hot-zero.
- `Frame_tick`  out  1  one-cycle pulse at each frame start.

## Operation
- **Reset values:** `Seg_out`=7'h7F, `Dp_out`=1, `An_out`=all ones, `Frame_tick`=0. Internally: prescaler 0, digit index 0, shadow registers 0, state IDLE.
- **State machine:**
  - IDLE: outputs blanked; prescaler and index held at 0. `Enable`=1 moves to SCAN and loads the shadow from `Digits_in`/`Dp_in` on that same edge.
  - SCAN: `Enable`=0 returns to IDLE on the next edge. The prescaler and index clear, and outputs blank one cycle later.
- **Prescaler:** counts 0..`SCAN_DIV`-1 in SCAN. At terminal count it wraps to 0 and the index advances; index `NUM_DIGITS`-1 wraps to 0.
- **Frame start** is the edge where the index wraps to 0. On that edge the shadow reloads from `Digits_in`/`Dp_in` and `Frame_tick` pulses for one cycle.
- **Mid-frame changes:** `Digits_in` changes between frame starts have no effect on the display.
- **Decode:** codes 0–9 map to the standard patterns. Codes 10–15 are invalid and display a dash: only segment g lit, `Seg_out`=7'b0111111.
- **Anode select:** `An_out[k]`=0 only while index=k in SCAN. `Dp_out` = ~shadow_dp[index].
- **Width rules:** prescaler width is clog2(`SCAN_DIV`); index width is clog2(`NUM_DIGITS`), minimum 1. Neither counter may reach an out-of-range value.
- **Async reset** mid-frame returns immediately to the reset values; there is no partial-frame recovery.

## Timing
- All outputs are registered: they reflect the state and index of the previous cycle, giving 1-cycle latency.
- Each digit is driven for exactly `SCAN_DIV` consecutive cycles. A frame is `NUM_DIGITS`×`SCAN_DIV` cycles.
- First valid digit: `Enable` is sampled high at edge E; digit 0 appears on the outputs after edge E+1.
- `Frame_tick` is high for the cycle following each frame-start edge, aligned with digit 0 appearing on `An_out`. No tick is generated for the IDLE→SCAN transition.
- `Enable` dropping for a single cycle forces a full restart from digit 0 with a fresh shadow load.

## Configuration
- `BCD_LEADING_ZERO_BLANK_EN` defined: any shadow digit of value 0 that is more significant than the highest nonzero digit drives `Seg_out`=7'h7F.
  - Its anode is still asserted, and its decimal point is still honoured.
  - Digit 0 is never blanked.
  - Blank flags are computed from the shadow at frame load, so they are stable for the whole frame.
- Macro undefined: all digits are decoded normally and leading zeros are displayed.

## Structure
- Shared package `stopwatch_pkg` holds:
  - the seven segment-pattern constants for 0–9;
  - the dash and blank constants (`SEG_DASH`, `SEG_BLANK`);
  - the scanner state enum `{IDLE, SCAN}`.
- One sub-module: `bcd_to_seg`, a purely combinational decoder from 4-bit code to 7-bit active-low pattern, including the dash for invalid codes. It is instantiated once, on the muxed shadow digit.

## Test plan
Bench configuration: `NUM_DIGITS`=4, `SCAN_DIV`=4.
- **Reset:** assert `nReset`=0 mid-scan → `Seg_out`=7'h7F, `Dp_out`=1, `An_out`=4'b1111 and `Frame_tick`=0 asynchronously. After release with `Enable`=0, outputs stay blank.
- **Basic scan:** `Digits_in`=16'h1234, `Enable`=1.
  - `An_out` steps 1110→1101→1011→0111, 4 cycles each.
  - `Seg_out` steps 7'b0011001 (4), 7'b0110000 (3), 7'b0100100 (2), 7'b1111001 (1).
  - `Frame_tick` pulses every 16 cycles.
- **Tear-free update:** change `Digits_in` to 16'h9999 during digit 1 → the remainder of the frame still shows 3, 2, 1. The first 9 appears together with the next `Frame_tick`.
- **Invalid code and decimal point:** `Digits_in`=16'h00A0 with `Dp_in`=4'b0010 → digit 1 shows `Seg_out`=7'b0111111 with `Dp_out`=0. All other digits have `Dp_out`=1.
- **Leading-zero blanking:** `Digits_in`=16'h0050.
  - With the macro: digits 3 and 2 show 7'h7F, digit 1 shows 7'b0010010 (5), digit 0 shows 7'b1000000 (0).
  - Without the macro: digits 3 and 2 show 7'b1000000.
- **Enable drop:** drop `Enable` for 1 cycle during digit 2 → outputs blank for one cycle, then restart at digit 0 with a new shadow load and a full 4-cycle dwell.
